frame_capture_pingpong: RTL and testbench

//  Pass-through pixel-stream tap that captures whole frames into a ping-pong pair of BRAM banks.

---
 rtl/frame_capture_pingpong_if.sv | 24 ++
 rtl/frame_capture_pingpong.sv | 211 +++++++++++++++++++++
 tb/tb_frame_capture_pingpong.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_pingpong_if.sv
// Pixel stream bundle around the frame capture tap: the upstream side (x_*)
// and the pass-through downstream side (y_*). The slave view is the tap and
// the master view is whoever sources the stream and sinks the pass-through.
interface frame_capture_pingpong_if #(
  parameter int W = 8
);
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_data;
  logic         x_sof;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y_data;

  modport master (
    output x_valid, x_data, x_sof, y_ready,
    input  x_ready, y_valid, y_data
  );

  modport slave (
    input  x_valid, x_data, x_sof, y_ready,
    output x_ready, y_valid, y_data
  );
endinterface

// File: rtl/frame_capture_pingpong.sv
// Pass-through pixel tap that captures whole frames into a ping-pong pair of
// BRAM banks. Capture never stalls the stream: when the reader holds its bank
// at frame end the frame is dropped and counted. The bank handed to the reader
// is never the one being written.
module frame_capture_pingpong #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W          = 8,
  parameter int DECIM      = 1,
  parameter int DROP_W     = 8,
  localparam int AW = $clog2((IMG_WIDTH / DECIM) * (IMG_HEIGHT / DECIM))
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_capture_pingpong_if.slave strm,
  input  logic              mode_cont,
  input  logic              arm,
  input  logic              rd_lock,
  output logic              bram_we,
  output logic              bram_bank,
  output logic [AW-1:0]     bram_addr,
  output logic [W-1:0]      bram_data,
  output logic              rd_bank,
  output logic              rd_bank_valid,
  output logic              frame_complete,
  output logic              sync_err,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  localparam int XW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DSH = $clog2(DECIM);
  localparam int OW  = IMG_WIDTH / DECIM;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [XW-1:0]       x_pos_r, x_pos_s, cur_x_s;
  logic [YW-1:0]       y_pos_r, y_pos_s, cur_y_s;
  logic                hs_s, sof_hs_s, at_origin_s, last_px_s, decim_hit_s;
  logic                x_ready_s, commit_s;
  logic                y_valid_r;
  logic [W-1:0]        y_data_r;
  logic                wr_bank_r, rd_bank_r, rd_bank_valid_r;
  logic                frame_complete_r, sync_err_r;
  logic [DROP_W-1:0]   drop_count_r;

  // Ready depends only on the pass-through register, never on capture state.
  assign x_ready_s    = strm.y_ready | ~y_valid_r;
  assign strm.x_ready = x_ready_s;
  assign strm.y_valid = y_valid_r;
  assign strm.y_data  = y_data_r;

  // Position of the pixel being offered this cycle; an accepted SOF forces (0,0).
  always_comb begin
    hs_s        = strm.x_valid & x_ready_s;
    sof_hs_s    = hs_s & strm.x_sof;
    at_origin_s = (x_pos_r == {XW{1'b0}}) && (y_pos_r == {YW{1'b0}});
    if (sof_hs_s) begin
      cur_x_s = {XW{1'b0}};
      cur_y_s = {YW{1'b0}};
    end else begin
      cur_x_s = x_pos_r;
      cur_y_s = y_pos_r;
    end
    last_px_s   = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
    decim_hit_s = ((cur_x_s & X_MASK) == {XW{1'b0}}) && ((cur_y_s & Y_MASK) == {YW{1'b0}});
  end

  // Raster advance of the position counters on every accepted pixel.
  always_comb begin
    x_pos_s = x_pos_r;
    y_pos_s = y_pos_r;
    if (hs_s) begin
      if (cur_x_s == X_LAST) begin
        x_pos_s = {XW{1'b0}};
        if (cur_y_s == Y_LAST) begin
          y_pos_s = {YW{1'b0}};
        end else begin
          y_pos_s = cur_y_s + YW'(1);
        end
      end else begin
        x_pos_s = cur_x_s + XW'(1);
        y_pos_s = cur_y_s;
      end
    end else begin
      x_pos_s = x_pos_r;
      y_pos_s = y_pos_r;
    end
  end

  // Capture FSM next state; commit fires on the last pixel of a captured frame.
  always_comb begin
    state_s  = state_r;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mode_cont | arm) begin
          state_s = ST_WAIT_SOF;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_SOF: begin
        if (sof_hs_s) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_WAIT_SOF;
        end
      end
      ST_CAPTURE: begin
        if (hs_s & last_px_s) begin
          commit_s = 1'b1;
          if (mode_cont) begin
            state_s = ST_CAPTURE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (arm | mode_cont) begin
          state_s = ST_WAIT_SOF;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // BRAM write port: decimated pixels of a frame being captured, subsampled
  // address built from shifts of the current position.
  always_comb begin
    bram_we   = hs_s & ((state_r == ST_CAPTURE) | ((state_r == ST_WAIT_SOF) & strm.x_sof))
                & decim_hit_s;
    bram_addr = AW'(cur_y_s >> DSH) * AW'(OW) + AW'(cur_x_s >> DSH);
    bram_data = strm.x_data;
    bram_bank = wr_bank_r;
  end

  // State, position and one-stage pass-through register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      x_pos_r   <= {XW{1'b0}};
      y_pos_r   <= {YW{1'b0}};
      y_valid_r <= 1'b0;
      y_data_r  <= {W{1'b0}};
    end else begin
      state_r <= state_s;
      x_pos_r <= x_pos_s;
      y_pos_r <= y_pos_s;
      if (hs_s) begin
        y_valid_r <= 1'b1;
        y_data_r  <= strm.x_data;
      end else if (strm.y_ready) begin
        y_valid_r <= 1'b0;
      end
    end
  end

  // Bank swap or drop at frame end, plus the single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_r        <= 1'b0;
      rd_bank_r        <= 1'b0;
      rd_bank_valid_r  <= 1'b0;
      frame_complete_r <= 1'b0;
      sync_err_r       <= 1'b0;
      drop_count_r     <= {DROP_W{1'b0}};
    end else begin
      frame_complete_r <= commit_s & ~rd_lock;
      sync_err_r       <= sof_hs_s & ~at_origin_s;
      if (commit_s) begin
        if (rd_lock) begin
          // Reader still owns its bank: keep writing the same bank next frame.
          if (drop_count_r != {DROP_W{1'b1}}) begin
            drop_count_r <= drop_count_r + DROP_W'(1);
          end
        end else begin
          rd_bank_r       <= wr_bank_r;
          wr_bank_r       <= ~wr_bank_r;
          rd_bank_valid_r <= 1'b1;
        end
      end
    end
  end

  assign rd_bank        = rd_bank_r;
  assign rd_bank_valid  = rd_bank_valid_r;
  assign frame_complete = frame_complete_r;
  assign sync_err       = sync_err_r;
  assign drop_count     = drop_count_r;
  assign busy           = (state_r == ST_WAIT_SOF) || (state_r == ST_CAPTURE);

endmodule

// File: tb/tb_frame_capture_pingpong.sv
// Randomised bench for frame_capture_pingpong on a small 16x8 frame with
// 2x decimation. A linear-index frame model predicts writes, bank handover,
// drops, sync errors and the pass-through stream.
module tb_frame_capture_pingpong;
  localparam int IW  = 16;
  localparam int IH  = 8;
  localparam int DW  = 8;
  localparam int D   = 2;
  localparam int DRW = 2;
  localparam int N   = IW * IH;
  localparam int AW  = $clog2((IW / D) * (IH / D));
  localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_cont = 1'b0, arm = 1'b0, rd_lock = 1'b0;
  logic bram_we, bram_bank, rd_bank, rd_bank_valid, frame_complete, sync_err, busy;
  logic [AW-1:0]  bram_addr;
  logic [DW-1:0]  bram_data;
  logic [DRW-1:0] drop_count;

  frame_capture_pingpong_if #(.W(DW)) sif ();

  frame_capture_pingpong #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(DW), .DECIM(D), .DROP_W(DRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .strm(sif.slave),
    .mode_cont(mode_cont), .arm(arm), .rd_lock(rd_lock),
    .bram_we(bram_we), .bram_bank(bram_bank), .bram_addr(bram_addr), .bram_data(bram_data),
    .rd_bank(rd_bank), .rd_bank_valid(rd_bank_valid), .frame_complete(frame_complete),
    .sync_err(sync_err), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int m_st, m_pos, m_wr, m_rd, m_rdv, m_drop, m_fc, m_se, m_yv;
  logic [DW-1:0] m_yd;
  logic [DW-1:0] y_q[$];
  int sof_target = 0;
  int lock_mode  = 0;
  int fc_seen    = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pos = 0; m_wr = 0; m_rd = 0; m_rdv = 0;
    m_drop = 0; m_fc = 0; m_se = 0; m_yv = 0; m_yd = '0;
    y_q.delete();
  endtask

  task automatic check_zero_outputs();
    check_val("rst_y_valid", sif.y_valid, 0);
    check_val("rst_fc", frame_complete, 0);
    check_val("rst_sync_err", sync_err, 0);
    check_val("rst_rd_bank", rd_bank, 0);
    check_val("rst_rd_valid", rd_bank_valid, 0);
    check_val("rst_drop", drop_count, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_we", bram_we, 0);
  endtask

  task automatic drive(int pv, int pr);
    sif.x_valid = ($urandom % 100) < pv;
    sif.x_data  = DW'($urandom);
    sif.y_ready = ($urandom % 100) < pr;
    sif.x_sof   = (m_pos == sof_target) && (($urandom % 4) != 0);
    if (lock_mode == 2) rd_lock = ($urandom % 3) == 0;
    else                rd_lock = (lock_mode == 1);
  endtask

  // one clock: check combinational outputs, advance model, check registered outputs
  task automatic step();
    int cur, cx, cy;
    bit hs, exr, writing, ewe;
    #1;
    exr = sif.y_ready | (m_yv == 0);
    check_val("x_ready", sif.x_ready, exr);
    hs  = sif.x_valid && exr;
    cur = (hs && sif.x_sof) ? 0 : m_pos;
    cx  = cur % IW;
    cy  = cur / IW;
    writing = (m_st == M_CAP) || (m_st == M_WAIT && sif.x_sof);
    ewe = hs && writing && (cx % D == 0) && (cy % D == 0);
    check_val("bram_we", bram_we, ewe);
    if (ewe) begin
      check_val("bram_addr", bram_addr, (cy / D) * (IW / D) + cx / D);
      check_val("bram_bank", bram_bank, m_wr);
      check_val("bram_data", bram_data, sif.x_data);
    end
    if (m_yv != 0 && sif.y_ready && y_q.size() > 0)
      check_val("y_stream", sif.y_data, y_q.pop_front());

    m_fc = 0; m_se = 0;
    case (m_st)
      M_IDLE: if (mode_cont || arm) m_st = M_WAIT;
      M_WAIT: if (hs && sif.x_sof) m_st = M_CAP;
      M_CAP: if (hs && cur == N - 1) begin
        if (rd_lock) begin
          if (m_drop < (1 << DRW) - 1) m_drop++;
        end else begin
          m_rd = m_wr; m_wr = 1 - m_wr; m_rdv = 1; m_fc = 1;
        end
        m_st = mode_cont ? M_CAP : M_DONE;
      end
      M_DONE: if (arm || mode_cont) m_st = M_WAIT;
      default: m_st = M_IDLE;
    endcase
    if (hs) begin
      if (sif.x_sof && m_pos != 0) m_se = 1;
      m_pos = (cur + 1) % N;
      y_q.push_back(sif.x_data);
      m_yv = 1; m_yd = sif.x_data;
    end else if (sif.y_ready) begin
      m_yv = 0;
    end

    @(negedge clk);
    check_val("y_valid", sif.y_valid, m_yv);
    if (m_yv != 0) check_val("y_data", sif.y_data, m_yd);
    check_val("rd_bank", rd_bank, m_rd);
    check_val("rd_bank_valid", rd_bank_valid, m_rdv);
    check_val("frame_complete", frame_complete, m_fc);
    check_val("sync_err", sync_err, m_se);
    check_val("drop_count", drop_count, m_drop);
    check_val("busy", busy, (m_st == M_WAIT) || (m_st == M_CAP));
    if (frame_complete) fc_seen++;
  endtask

  task automatic run(int n, int pv, int pr);
    for (int i = 0; i < n; i++) begin
      drive(pv, pr);
      step();
    end
  endtask

  initial begin
    sif.x_valid = 1'b0; sif.x_data = '0; sif.x_sof = 1'b0; sif.y_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs();
    rst_n = 1'b1;

    // continuous capture, free reader
    mode_cont = 1'b1; lock_mode = 0;
    run(700, 80, 70);
    // reader locked across several frame ends: drops saturate
    lock_mode = 1;
    run(1100, 90, 90);
    // lock toggling randomly
    lock_mode = 2;
    run(400, 80, 70);
    // SOF injected mid-frame
    lock_mode = 0; sof_target = 50;
    run(200, 80, 80);
    sof_target = 0;
    // single-shot: arm once, stream several frames, then re-arm
    mode_cont = 1'b0;
    run(300, 90, 90);
    arm = 1'b1; run(1, 90, 90); arm = 1'b0;
    run(1000, 90, 90);
    arm = 1'b1; run(1, 90, 90); arm = 1'b0;
    run(500, 90, 90);
    // continuous again, then asynchronous reset mid-frame
    mode_cont = 1'b1;
    run(150, 70, 60);
    sif.x_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_zero_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(400, 85, 75);

    check_val("frames_seen", (fc_seen > 0) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
